tinytpu_stream_top: RTL and testbench

//  Parametrised successor to the tinytpu top level: multi-lane serial operand load, skewed systolic feed,

---
 rtl/tinytpu_pkg.sv | 31 +++
 rtl/tpu_skew_feeder.sv | 34 +++
 rtl/tpu_systolic_core.sv | 54 +++++
 rtl/tinytpu_stream_top.sv | 148 ++++++++++++++
 tb/tb_tinytpu_stream_top.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinytpu_pkg.sv
// rtl/tinytpu_pkg.sv - shared FSM type and sizing helpers for the streaming tinytpu
package tinytpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_UNLOAD  = 2'd3
    } state_t;

    function automatic int load_beats(input int n, input int d_w, input int lanes);
        return n * n * d_w / lanes;
    endfunction

    function automatic int out_beats(input int n, input int d_w, input int lanes);
        return n * n * 2 * d_w / lanes;
    endfunction

    function automatic int comp_cyc(input int n);
        return 3 * n - 1;
    endfunction

    function automatic int cnt_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic bit lanes_legal(input int d_w, input int lanes);
        return (lanes > 0) && (d_w % lanes == 0);
    endfunction

endpackage

// File: rtl/tpu_skew_feeder.sv
// rtl/tpu_skew_feeder.sv - diagonal skew mux from operand buffers into the systolic edges
module tpu_skew_feeder #(
    parameter int D_W = 8,
    parameter int N   = 2,
    parameter int T_W = 3
) (
    input  logic                 i_active,
    input  logic [T_W-1:0]       i_t,
    input  logic [N*N*D_W-1:0]   i_x_buf,
    input  logic [N*N*D_W-1:0]   i_y_buf,
    output logic [N*D_W-1:0]     o_x_flat,
    output logic [N*D_W-1:0]     o_y_flat
);
    import tinytpu_pkg::*;

    localparam int OP_BITS = N * N * D_W;

    // Buffers hold element [0][0] in the top D_W bits (first loaded, MSB-first).
    always_comb begin
        o_x_flat = '0;
        o_y_flat = '0;
        if (i_active) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(i_t) == i + k) begin
                        o_x_flat[i*D_W +: D_W] = i_x_buf[OP_BITS-1-(i*N+k)*D_W -: D_W];
                        o_y_flat[i*D_W +: D_W] = i_y_buf[OP_BITS-1-(k*N+i)*D_W -: D_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tpu_systolic_core.sv
// rtl/tpu_systolic_core.sv - NxN output-stationary systolic MAC array
module tpu_systolic_core #(
    parameter int D_W = 8,
    parameter int N   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_init,
    input  logic [N*D_W-1:0]       i_x_flat,
    input  logic [N*D_W-1:0]       i_y_flat,
    output logic [N*N*2*D_W-1:0]   o_z_flat
);
    localparam int Z_W = 2 * D_W;

    logic [D_W-1:0] r_a   [N][N];
    logic [D_W-1:0] r_b   [N][N];
    logic [Z_W-1:0] r_acc [N][N];
    logic [D_W-1:0] w_a_in [N][N];
    logic [D_W-1:0] w_b_in [N][N];
    logic [Z_W-1:0] w_prod [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            // X flows rightwards along a row, Y flows downwards along a column
            if (j == 0) begin : g_a_edge
                assign w_a_in[i][j] = i_x_flat[i*D_W +: D_W];
            end else begin : g_a_chain
                assign w_a_in[i][j] = r_a[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign w_b_in[i][j] = i_y_flat[j*D_W +: D_W];
            end else begin : g_b_chain
                assign w_b_in[i][j] = r_b[i-1][j];
            end

            assign w_prod[i][j] = Z_W'(w_a_in[i][j]) * Z_W'(w_b_in[i][j]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_acc[i][j] <= '0;
                end else begin
                    r_a[i][j]   <= w_a_in[i][j];
                    r_b[i][j]   <= w_b_in[i][j];
                    r_acc[i][j] <= i_init ? w_prod[i][j] : r_acc[i][j] + w_prod[i][j];
                end
            end

            assign o_z_flat[(i*N+j)*Z_W +: Z_W] = r_acc[i][j];
        end
    end

endmodule

// File: rtl/tinytpu_stream_top.sv
// rtl/tinytpu_stream_top.sv - serial-load / systolic-compute / serial-unload matrix multiplier top
module tinytpu_stream_top #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] data_in_x,
    input  logic [LANES-1:0] data_in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] data_out_z,
    output logic             busy,
    output logic             done
);
    import tinytpu_pkg::*;

    localparam int LOAD_BEATS = load_beats(N, D_W, LANES);
    localparam int OUT_BEATS  = out_beats(N, D_W, LANES);
    localparam int COMP_CYC   = comp_cyc(N);
    localparam int Z_W        = 2 * D_W;
    localparam int OP_BITS    = N * N * D_W;
    localparam int RES_BITS   = N * N * Z_W;
    localparam int BEAT_W     = cnt_w(OUT_BEATS);
    localparam int T_W        = cnt_w(COMP_CYC);

    if (!lanes_legal(D_W, LANES)) begin : g_lanes_illegal
        $error("tinytpu_stream_top: LANES must divide D_W");
    end

    state_t              r_state;
    state_t              w_next;
    logic                r_acc_mode;
    logic [BEAT_W-1:0]   r_beat;
    logic [T_W-1:0]      r_t;
    logic [OP_BITS-1:0]  r_x;
    logic [OP_BITS-1:0]  r_y;
    logic [RES_BITS-1:0] r_z;
    logic                r_done;

    logic                w_load_hs;
    logic                w_load_last;
    logic                w_unload_hs;
    logic                w_unload_last;
    logic                w_comp_last;
    logic                w_core_init;
    logic [N*D_W-1:0]    w_x_feed;
    logic [N*D_W-1:0]    w_y_feed;
    logic [RES_BITS-1:0] w_core_z;
    logic [RES_BITS-1:0] w_z_cap;

    assign w_load_hs     = (r_state == S_LOAD) && in_valid;
    assign w_load_last   = (r_beat == BEAT_W'(LOAD_BEATS - 1));
    assign w_unload_hs   = (r_state == S_UNLOAD) && out_ready;
    assign w_unload_last = (r_beat == BEAT_W'(OUT_BEATS - 1));
    assign w_comp_last   = (r_t == T_W'(COMP_CYC - 1));
    assign w_core_init   = (r_state == S_COMPUTE) && (r_t == '0) && !r_acc_mode;

    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_UNLOAD);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign data_out_z = out_valid ? r_z[RES_BITS-1 -: LANES] : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    if (w_load_hs && w_load_last) w_next = S_COMPUTE;
            S_COMPUTE: if (w_comp_last) w_next = S_UNLOAD;
            S_UNLOAD:  if (w_unload_hs && w_unload_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Core numbers PEs row-major from bit 0; the unload buffer wants [0][0] at the MSB.
    always_comb begin
        w_z_cap = '0;
        for (int e = 0; e < N * N; e++) begin
            w_z_cap[RES_BITS-1-e*Z_W -: Z_W] = w_core_z[e*Z_W +: Z_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc_mode <= 1'b0;
            r_beat     <= '0;
            r_t        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_unload_hs && w_unload_last;
            if ((r_state == S_IDLE) && start) begin
                r_acc_mode <= acc_mode;
            end
            if (w_load_hs) begin
                r_x    <= {r_x[OP_BITS-LANES-1:0], data_in_x};
                r_y    <= {r_y[OP_BITS-LANES-1:0], data_in_y};
                r_beat <= w_load_last ? '0 : r_beat + BEAT_W'(1);
            end
            if (r_state == S_COMPUTE) begin
                r_t <= w_comp_last ? '0 : r_t + T_W'(1);
                if (w_comp_last) begin
                    r_z <= w_z_cap;
                end
            end
            if (w_unload_hs) begin
                r_z    <= r_z << LANES;
                r_beat <= w_unload_last ? '0 : r_beat + BEAT_W'(1);
            end
        end
    end

    tpu_skew_feeder #(
        .D_W (D_W),
        .N   (N),
        .T_W (T_W)
    ) u_feeder (
        .i_active (r_state == S_COMPUTE),
        .i_t      (r_t),
        .i_x_buf  (r_x),
        .i_y_buf  (r_y),
        .o_x_flat (w_x_feed),
        .o_y_flat (w_y_feed)
    );

    tpu_systolic_core #(
        .D_W (D_W),
        .N   (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_init   (w_core_init),
        .i_x_flat (w_x_feed),
        .i_y_flat (w_y_feed),
        .o_z_flat (w_core_z)
    );

endmodule

// File: tb/tb_tinytpu_stream_top.sv
// tb/tb_tinytpu_stream_top.sv - randomized self-checking bench for tinytpu_stream_top
`timescale 1ns/1ps
module tb_tinytpu_stream_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, acc_mode, in_valid, out_ready;
    logic [0:0] data_in_x, data_in_y, data_out_z;
    logic       in_ready, out_valid, busy, done;

    logic       rst_w, start_w, acc_w, in_valid_w, out_ready_w;
    logic [3:0] x_w, y_w, z_w;
    logic       in_ready_w, out_valid_w, busy_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] g_x, g_y;
    logic [63:0] model_z;

    tinytpu_stream_top u_dut (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in_x(data_in_x), .data_in_y(data_in_y),
        .out_valid(out_valid), .out_ready(out_ready), .data_out_z(data_out_z),
        .busy(busy), .done(done)
    );

    tinytpu_stream_top #(.D_W(8), .N(3), .LANES(4)) u_dut_w (
        .clk(clk), .rst(rst_w), .start(start_w), .acc_mode(acc_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .data_in_x(x_w), .data_in_y(y_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .data_out_z(z_w),
        .busy(busy_w), .done(done_w)
    );

    // Reference: plain integer matrix product, element [0][0] in the top bits.
    function automatic logic [63:0] matmul2(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] z;
        int s;
        z = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'(x[31-(i*2+k)*8 -: 8]) * int'(y[31-(k*2+j)*8 -: 8]);
                z[63-(i*2+j)*16 -: 16] = s[15:0];
            end
        end
        return z;
    endfunction

    function automatic logic [63:0] addz(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] z;
        for (int e = 0; e < 4; e++) z[e*16 +: 16] = a[e*16 +: 16] + b[e*16 +: 16];
        return z;
    endfunction

    task automatic rand_operands();
        for (int b = 0; b < 4; b++) begin
            g_x[b*8 +: 8] = 8'($urandom);
            g_y[b*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic do_job(input bit acc, input int vpct, input int rpct, input bit stall10,
                          input bit abuse, input int abort_load, input int abort_unload,
                          output logic [63:0] zgot, output int lat, output int ndone,
                          output bit stable_ok, output bit tmo, output bit aborted);
        int beat, ob, cyc, stall_cnt;
        bit hs, prev_stall;
        logic [0:0] prev_z;
        zgot = '0; lat = -1; ndone = 0; stable_ok = 1'b1; tmo = 1'b0; aborted = 1'b0;
        prev_stall = 1'b0; prev_z = '0; stall_cnt = 0;
        start = 1'b1; acc_mode = acc;
        @(negedge clk);
        start = 1'b0; acc_mode = 1'(~acc);
        beat = 0; cyc = 0;
        while (beat < 32 && !tmo && !aborted) begin
            if (beat == abort_load) begin
                in_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; aborted = 1'b1;
            end else begin
                in_valid  = ($urandom_range(99) >= vpct);
                data_in_x = g_x[31-beat];
                data_in_y = g_y[31-beat];
                if (abuse) start = 1'($urandom);
                hs = in_valid && in_ready;
                ndone += int'(done);
                @(negedge clk);
                if (hs) beat++;
                cyc++;
                if (cyc > 2000) tmo = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!aborted && !tmo) begin
            lat = 1;
            while (!out_valid && lat < 100) begin
                if (abuse) start = 1'($urandom);
                out_ready = 1'($urandom);
                ndone += int'(done);
                @(negedge clk);
                lat++;
            end
            if (!out_valid) tmo = 1'b1;
        end
        ob = 0; cyc = 0;
        while (ob < 64 && !tmo && !aborted) begin
            if (ob == abort_unload) begin
                out_ready = 1'b0; rst = 1'b1; start = 1'b0;
                @(negedge clk);
                rst = 1'b0; aborted = 1'b1;
            end else begin
                if (prev_stall && (data_out_z !== prev_z)) stable_ok = 1'b0;
                if (stall10 && ob == 10 && stall_cnt < 5) begin
                    out_ready = 1'b0; stall_cnt++;
                end else begin
                    out_ready = ($urandom_range(99) >= rpct);
                end
                if (abuse) start = 1'($urandom);
                hs = out_valid && out_ready;
                if (hs) zgot[63-ob] = data_out_z;
                prev_stall = out_valid && !out_ready;
                prev_z = data_out_z;
                ndone += int'(done);
                @(negedge clk);
                if (hs) ob++;
                cyc++;
                if (cyc > 5000) tmo = 1'b1;
            end
        end
        out_ready = 1'b0; start = 1'b0;
        if (!aborted) begin
            ndone += int'(done);
            @(negedge clk);
            ndone += int'(done);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0000", {in_ready, out_valid, busy, done});
        end
        n_tests++;
        if (data_out_z !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got=%b exp=0", data_out_z);
        end
        n_tests++;
        if ({in_ready_w, out_valid_w, busy_w, done_w, z_w} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wide got=%h exp=00", {in_ready_w, out_valid_w, busy_w, done_w, z_w});
        end
        rst = 1'b0; rst_w = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        logic [63:0] z; int lat, nd; bit st, tmo, ab;
        g_x = {8'd1, 8'd2, 8'd3, 8'd4};
        g_y = {8'd5, 8'd6, 8'd7, 8'd8};
        model_z = matmul2(g_x, g_y);
        do_job(1'b0, 0, 0, 1'b0, 1'b0, -1, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (tmo || z !== model_z) begin
            n_fail++;
            $display("FAIL basic_z got=%h exp=%h tmo=%0d", z, model_z, tmo);
        end
        n_tests++;
        if (z !== 64'h0013_0016_002B_0032) begin
            n_fail++;
            $display("FAIL basic_z_const got=%h exp=0013_0016_002b_0032", z);
        end
        n_tests++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL basic_latency got=%0d exp=6", lat);
        end
        n_tests++;
        if (nd !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done got=%0d busy=%b exp=1 busy=0", nd, busy);
        end
    endtask

    task automatic test_accumulate();
        logic [63:0] z; int lat, nd; bit st, tmo, ab;
        model_z = addz(model_z, matmul2(g_x, g_y));
        do_job(1'b1, 0, 0, 1'b0, 1'b0, -1, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (tmo || z !== model_z) begin
            n_fail++;
            $display("FAIL acc_z got=%h exp=%h", z, model_z);
        end
        n_tests++;
        if (z !== 64'h0026_002C_0056_0064) begin
            n_fail++;
            $display("FAIL acc_z_const got=%h exp=0026_002c_0056_0064", z);
        end
        model_z = matmul2(g_x, g_y);
        do_job(1'b0, 0, 0, 1'b0, 1'b0, -1, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (tmo || z !== model_z) begin
            n_fail++;
            $display("FAIL acc_clear_z got=%h exp=%h", z, model_z);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] z; int lat, nd; bit st, tmo, ab, acc;
        for (int r = 0; r < 2; r++) begin
            rand_operands();
            acc = 1'($urandom);
            model_z = acc ? addz(model_z, matmul2(g_x, g_y)) : matmul2(g_x, g_y);
            do_job(acc, 40, 30, 1'b1, 1'b0, -1, -1, z, lat, nd, st, tmo, ab);
            n_tests++;
            if (tmo || z !== model_z) begin
                n_fail++;
                $display("FAIL bp_z run=%0d got=%h exp=%h", r, z, model_z);
            end
            n_tests++;
            if (!st || nd !== 1) begin
                n_fail++;
                $display("FAIL bp_stable run=%0d stable=%0d done=%0d exp=1/1", r, st, nd);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z; int lat, nd; bit st, tmo, ab;
        g_x = {8'd1, 8'd2, 8'd3, 8'd4};
        g_y = {8'd5, 8'd6, 8'd7, 8'd8};
        do_job(1'b1, 10, 0, 1'b0, 1'b0, 17, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (!ab || {busy, in_ready, out_valid, done, data_out_z} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_load aborted=%0d got=%b exp=00000", ab,
                     {busy, in_ready, out_valid, done, data_out_z});
        end
        do_job(1'b1, 0, 10, 1'b0, 1'b0, -1, 30, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (!ab || {busy, in_ready, out_valid, done, data_out_z} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_unload aborted=%0d got=%b exp=00000", ab,
                     {busy, in_ready, out_valid, done, data_out_z});
        end
        model_z = addz(64'd0, matmul2(g_x, g_y));
        do_job(1'b1, 0, 0, 1'b0, 1'b0, -1, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (tmo || z !== model_z || z !== 64'h0013_0016_002B_0032) begin
            n_fail++;
            $display("FAIL rst_fresh_z got=%h exp=%h", z, model_z);
        end
    endtask

    task automatic test_abuse();
        logic [63:0] z; int lat, nd; bit st, tmo, ab, bad;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; data_in_x = 1'($urandom); data_in_y = 1'($urandom);
            out_ready = 1'($urandom); acc_mode = 1'($urandom);
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abuse_idle in_ready=%b busy=%b exp=0/0", in_ready, busy);
        end
        model_z = matmul2(g_x, g_y);
        do_job(1'b0, 20, 20, 1'b0, 1'b1, -1, -1, z, lat, nd, st, tmo, ab);
        n_tests++;
        if (tmo || z !== model_z || nd !== 1) begin
            n_fail++;
            $display("FAIL abuse_z got=%h exp=%h done=%0d", z, model_z, nd);
        end
    endtask

    task automatic test_random();
        logic [63:0] z; int lat, nd; bit st, tmo, ab, acc;
        for (int r = 0; r < 6; r++) begin
            rand_operands();
            acc = 1'($urandom);
            model_z = acc ? addz(model_z, matmul2(g_x, g_y)) : matmul2(g_x, g_y);
            do_job(acc, $urandom_range(50), $urandom_range(50), 1'b0, 1'b0, -1, -1,
                   z, lat, nd, st, tmo, ab);
            n_tests++;
            if (tmo || z !== model_z) begin
                n_fail++;
                $display("FAIL random_z run=%0d acc=%0d got=%h exp=%h", r, acc, z, model_z);
            end
        end
    endtask

    task automatic test_wide();
        logic [71:0] wx, wy;
        logic [143:0] wexp, wgot;
        int s, beat, ob, cyc;
        bit hs;
        for (int job = 0; job < 2; job++) begin
            for (int b = 0; b < 9; b++) begin
                wx[b*8 +: 8] = (job == 0) ? 8'hFF : 8'($urandom);
                wy[b*8 +: 8] = (job == 0) ? 8'hFF : 8'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    s = 0;
                    for (int k = 0; k < 3; k++)
                        s += int'(wx[71-(i*3+k)*8 -: 8]) * int'(wy[71-(k*3+j)*8 -: 8]);
                    wexp[143-(i*3+j)*16 -: 16] = s[15:0];
                end
            end
            wgot = '0;
            start_w = 1'b1; acc_w = 1'b0;
            @(negedge clk);
            start_w = 1'b0;
            beat = 0; cyc = 0;
            while (beat < 18 && cyc < 200) begin
                in_valid_w = 1'b1;
                x_w = wx[71-4*beat -: 4];
                y_w = wy[71-4*beat -: 4];
                hs = in_valid_w && in_ready_w;
                @(negedge clk);
                if (hs) beat++;
                cyc++;
            end
            in_valid_w = 1'b0;
            n_tests++;
            if (beat !== 18 || in_ready_w !== 1'b0) begin
                n_fail++;
                $display("FAIL wide_load job=%0d beats=%0d in_ready=%b exp=18/0", job, beat, in_ready_w);
            end
            out_ready_w = 1'b1;
            cyc = 0;
            while (!out_valid_w && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            ob = 0; cyc = 0;
            while (out_valid_w && cyc < 500) begin
                if (ob < 36) wgot[143-4*ob -: 4] = z_w;
                ob++;
                @(negedge clk);
                cyc++;
            end
            out_ready_w = 1'b0;
            n_tests++;
            if (ob !== 36 || done_w !== 1'b1) begin
                n_fail++;
                $display("FAIL wide_unload job=%0d beats=%0d done=%b exp=36/1", job, ob, done_w);
            end
            n_tests++;
            if (wgot !== wexp) begin
                n_fail++;
                $display("FAIL wide_z job=%0d got=%h exp=%h", job, wgot, wexp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; acc_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in_x = '0; data_in_y = '0;
        rst_w = 1'b1; start_w = 1'b0; acc_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
        x_w = '0; y_w = '0;
        model_z = '0; g_x = '0; g_y = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_abuse();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
